// File: rtl/uart_fifo_tx_ctrl_pkg.sv
// Shared types and constants for the FIFO-to-UART transmit path.
// Holds the controller state encodings and the RS232 frame constants.
package uart_fifo_tx_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_LOAD = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_NEXT = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    RD   = ST_RD,
    LOAD = ST_LOAD,
    SEND = ST_SEND,
    NEXT = ST_NEXT
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/uart_fifo_tx_ctrl_byte_tx.sv
// Serialises one byte as an 8N1 RS232 frame, LSB first.
// A start strobe is accepted only while no frame is in progress.
module uart_byte_tx
  import uart_fifo_tx_ctrl_pkg::*;
#(
  parameter int UART_BPS = 9600,
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n_sync,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       tx,
  output logic       byte_done
);

  localparam int BIT_CNT = CLK_FREQ / UART_BPS;
  localparam int CW = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

  logic          active;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    data_r;
  logic          bit_end;
  logic          last_bit;

  assign bit_end   = active && (bit_cnt == CW'(BIT_CNT - 1));
  assign last_bit  = (bit_idx == 4'(FRAME_BITS - 1));
  assign byte_done = bit_end && last_bit;

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      active  <= 1'b0;
      bit_cnt <= '0;
      bit_idx <= '0;
      data_r  <= '0;
      tx      <= STOP_BIT;
    end else if (!active) begin
      if (pi_flag) begin
        active  <= 1'b1;
        data_r  <= pi_data;
        bit_cnt <= '0;
        bit_idx <= '0;
        tx      <= START_BIT;
      end
    end else if (bit_end) begin
      bit_cnt <= '0;
      if (last_bit) begin
        active  <= 1'b0;
        bit_idx <= '0;
        tx      <= STOP_BIT;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        // idx k moves to k+1, which carries data bit k
        tx      <= (bit_idx == 4'd8) ? STOP_BIT
                                     : data_r[bit_idx[2:0]];
      end
    end else begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_fifo_tx_ctrl.sv
// Drains words from the read FIFO and sends them MSB byte first on tx.
// Owns the reset synchroniser, word sequencing FSM and byte selection.
module uart_fifo_tx_ctrl
  import uart_fifo_tx_ctrl_pkg::*;
#(
  parameter int UART_BPS      = 9600,
  parameter int CLK_FREQ      = 50_000_000,
  parameter int FIFO_RD_WIDTH = 16,
  parameter int FIFO_RD_BYTE  = FIFO_RD_WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fifo_empty,
  input  logic [FIFO_RD_WIDTH-1:0] fifo_rd_data,
  output logic                     fifo_rd_en,
  output logic                     tx,
  output logic                     busy
);

  localparam int BW = (FIFO_RD_BYTE > 1) ? $clog2(FIFO_RD_BYTE) : 1;

  logic [1:0] rst_sync;
  logic       rst_n_sync;

  // assert immediately, release after two clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_sync = rst_sync[1];

  state_t                   state, state_d;
  logic [FIFO_RD_WIDTH-1:0] shift_word, shift_d;
  logic [BW-1:0]            byte_cnt, byte_cnt_d;
  logic                     rd_en_d;
  logic                     busy_d;
  logic                     start_d;
  logic                     byte_start;
  logic                     byte_done;

  always_comb begin
    state_d    = state;
    shift_d    = shift_word;
    byte_cnt_d = byte_cnt;
    rd_en_d    = 1'b0;
    start_d    = 1'b0;
    busy_d     = busy;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = RD;
        end
      end
      RD: state_d = LOAD;
      LOAD: begin
        shift_d    = fifo_rd_data;
        byte_cnt_d = '0;
        start_d    = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (byte_done) state_d = NEXT;
      end
      NEXT: begin
        if (byte_cnt == BW'(FIFO_RD_BYTE - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          shift_d    = shift_word << 8;
          byte_cnt_d = byte_cnt + BW'(1);
          start_d    = 1'b1;
          state_d    = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state      <= IDLE;
      shift_word <= '0;
      byte_cnt   <= '0;
      fifo_rd_en <= 1'b0;
      byte_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      shift_word <= shift_d;
      byte_cnt   <= byte_cnt_d;
      fifo_rd_en <= rd_en_d;
      byte_start <= start_d;
      busy       <= busy_d;
    end
  end

  uart_byte_tx #(
    .UART_BPS (UART_BPS),
    .CLK_FREQ (CLK_FREQ)
  ) u_byte_tx (
    .clk        (clk),
    .rst_n_sync (rst_n_sync),
    .pi_data    (shift_word[FIFO_RD_WIDTH-1 -: 8]),
    .pi_flag    (byte_start),
    .tx         (tx),
    .byte_done  (byte_done)
  );

endmodule

// File: tb/tb_uart_fifo_tx_ctrl.sv
// Bench for uart_fifo_tx_ctrl: 16-bit and 32-bit instances fed by FIFO models,
// tx decoded by a behavioural receiver and checked against a byte scoreboard.
module tb_uart_fifo_tx_ctrl;

  localparam int CLK_FREQ = 1_000_000;
  localparam int UART_BPS = 100_000;
  localparam int BIT_CNT  = CLK_FREQ / UART_BPS;
  localparam int FRAME    = 10 * BIT_CNT;
  localparam int T_OUT    = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        empty16 = 1'b1;
  logic        empty32 = 1'b1;
  logic [15:0] rd16;
  logic [31:0] rd32;
  logic        rd_en16, rd_en32;
  logic        tx16, tx32;
  logic        busy16, busy32;

  uart_fifo_tx_ctrl #(
    .UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ),
    .FIFO_RD_WIDTH(16), .FIFO_RD_BYTE(2)
  ) dut16 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(empty16),
    .fifo_rd_data(rd16), .fifo_rd_en(rd_en16),
    .tx(tx16), .busy(busy16)
  );

  uart_fifo_tx_ctrl #(
    .UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ),
    .FIFO_RD_WIDTH(32), .FIFO_RD_BYTE(4)
  ) dut32 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(empty32),
    .fifo_rd_data(rd32), .fifo_rd_en(rd_en32),
    .tx(tx32), .busy(busy32)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] q16[$];
  logic [31:0] q32[$];
  logic [7:0]  exp_q[$];
  logic [15:0] exp_w[$];

  always @(posedge clk) cyc <= cyc + 1;

  // standard-mode FIFO: data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (rd_en16 && q16.size() > 0) rd16 <= q16.pop_front();
    if (rd_en32 && q32.size() > 0) rd32 <= q32.pop_front();
  end

  always @(negedge clk) begin
    empty16 = (q16.size() == 0);
    empty32 = (q32.size() == 0);
  end

  int   rd_cnt16 = 0, rd_cnt32 = 0;
  int   rd_cyc16 = 0, rd_cyc32 = 0;
  int   dbl_rd = 0;
  int   busy_cyc32 = 0;
  logic pbusy16 = 1'b0, pbusy32 = 1'b0;

  always @(negedge clk) begin
    if (rd_en16) begin
      rd_cnt16++;
      rd_cyc16 = cyc;
      if (pbusy16) dbl_rd++;
    end
    if (rd_en32) begin
      rd_cnt32++;
      rd_cyc32 = cyc;
      if (pbusy32) dbl_rd++;
    end
    if (busy32) busy_cyc32++;
    pbusy16 = busy16;
    pbusy32 = busy32;
    if (dut16.byte_start) begin
      checks++;
      assert (!dut16.u_byte_tx.active)
      else begin
        errors++;
        $display("FAIL strobe_while_busy16 at cycle %0d", cyc);
      end
    end
    if (dut32.byte_start) begin
      checks++;
      assert (!dut32.u_byte_tx.active)
      else begin
        errors++;
        $display("FAIL strobe_while_busy32 at cycle %0d", cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic line(input int sel);
    return (sel == 1) ? tx32 : tx16;
  endfunction

  function automatic logic bsy(input int sel);
    return (sel == 1) ? busy32 : busy16;
  endfunction

  // decode one frame; returns at the last stop-bit cycle
  task automatic rx_byte(input int sel, output logic [7:0] b,
                         output int s, output logic bz);
    int   n;
    logic st, sp;
    n  = 0;
    b  = '0;
    s  = -1;
    bz = 1'b0;
    while (line(sel) !== 1'b0 && n < T_OUT) begin
      @(negedge clk);
      n++;
    end
    chk("rx_timeout", 64'(n >= T_OUT), 64'd0);
    if (n < T_OUT) begin
      s = cyc;
      repeat (BIT_CNT / 2) @(negedge clk);
      st = line(sel);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT_CNT) @(negedge clk);
        b[i] = line(sel);
      end
      repeat (BIT_CNT) @(negedge clk);
      sp = line(sel);
      chk("frame_start_stop", {62'd0, st, sp}, 64'b01);
      repeat (BIT_CNT / 2 - 1) @(negedge clk);
      bz = bsy(sel);
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b, hi, lo, e;
    logic        bz;
    int          s0, s1, base, bad, n, wr_cnt;
    logic [15:0] w;

    vecs[0] = '{word: 16'hA55A, hi: 8'hA5, lo: 8'h5A};
    vecs[1] = '{word: 16'h0102, hi: 8'h01, lo: 8'h02};
    vecs[2] = '{word: 16'h0304, hi: 8'h03, lo: 8'h04};
    vecs[3] = '{word: 16'hFF00, hi: 8'hFF, lo: 8'h00};

    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_tx", 64'(tx16), 64'd1);
    chk("reset_busy", 64'(busy16), 64'd0);
    chk("reset_rd_en", 64'(rd_en16), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // empty FIFO: nothing moves
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rd_en16 || tx16 !== 1'b1 || busy16) bad++;
    end
    chk("empty_idle_violations", 64'(bad), 64'd0);
    chk("empty_rd_count", 64'(rd_cnt16), 64'd0);

    // single word through the table
    q16.push_back(vecs[0].word);
    exp_q.push_back(vecs[0].hi);
    exp_q.push_back(vecs[0].lo);
    rx_byte(0, b, s0, bz);
    e = exp_q.pop_front();
    chk("single_hi", 64'(b), 64'(e));
    chk("rd_to_start", 64'(s0 - rd_cyc16), 64'd3);
    rx_byte(0, b, s1, bz);
    e = exp_q.pop_front();
    chk("single_lo", 64'(b), 64'(e));
    chk("byte_gap", 64'(s1 - s0), 64'(FRAME + 2));
    chk("busy_last_stop", 64'(bz), 64'd1);
    repeat (2) @(negedge clk);
    chk("busy_fall", 64'(busy16), 64'd0);
    chk("single_rd_count", 64'(rd_cnt16), 64'd1);

    // back-to-back words from the table
    base = rd_cnt16;
    for (int i = 1; i < 4; i++) begin
      q16.push_back(vecs[i].word);
      exp_q.push_back(vecs[i].hi);
      exp_q.push_back(vecs[i].lo);
    end
    s0 = 0;
    for (int k = 0; k < 6; k++) begin
      rx_byte(0, b, s1, bz);
      e = exp_q.pop_front();
      chk("b2b_byte", 64'(b), 64'(e));
      if (k > 0)
        chk("b2b_gap", 64'(s1 - s0),
            64'((k % 2 == 1) ? FRAME + 2 : FRAME + 5));
      s0 = s1;
    end
    repeat (4) @(negedge clk);
    chk("b2b_rd_count", 64'(rd_cnt16 - base), 64'd3);
    chk("b2b_double_read", 64'(dbl_rd), 64'd0);

    // reset in frame bit 4 of byte 12
    q16.push_back(16'h1234);
    n = 0;
    while (tx16 !== 1'b0 && n < T_OUT) begin
      @(negedge clk);
      n++;
    end
    chk("rst_start_seen", 64'(n < T_OUT), 64'd1);
    repeat (4 * BIT_CNT + BIT_CNT / 2) @(negedge clk);
    chk("rst_pre_tx", 64'(tx16), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_tx", 64'(tx16), 64'd1);
    chk("rst_async_busy", 64'(busy16), 64'd0);
    q16.push_back(16'h5678);
    exp_q.push_back(8'h56);
    exp_q.push_back(8'h78);
    repeat (3) @(negedge clk);
    base = rd_cnt16;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rx_byte(0, b, s1, bz);
      e = exp_q.pop_front();
      chk("rst_next_word", 64'(b), 64'(e));
    end
    repeat (4) @(negedge clk);
    chk("rst_rd_count", 64'(rd_cnt16 - base), 64'd1);

    // loopback: rebuild words from the byte stream
    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      q16.push_back(w);
      exp_w.push_back(w);
    end
    wr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      rx_byte(0, hi, s1, bz);
      rx_byte(0, lo, s1, bz);
      w = exp_w.pop_front();
      chk("loopback_word", 64'({hi, lo}), 64'(w));
      wr_cnt++;
    end
    chk("loopback_count", 64'(wr_cnt), 64'd8);

    // 32-bit instance
    busy_cyc32 = 0;
    q32.push_back(32'hDEADBEEF);
    exp_q.push_back(8'hDE);
    exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hEF);
    s0 = 0;
    for (int k = 0; k < 4; k++) begin
      rx_byte(1, b, s1, bz);
      e = exp_q.pop_front();
      chk("w32_byte", 64'(b), 64'(e));
      if (k > 0) chk("w32_gap", 64'(s1 - s0), 64'(FRAME + 2));
      s0 = s1;
    end
    chk("w32_busy_last_stop", 64'(bz), 64'd1);
    repeat (2) @(negedge clk);
    chk("w32_busy_fall", 64'(busy32), 64'd0);
    // 4 frames, 3 two-cycle gaps, RD, LOAD, first strobe, final NEXT
    chk("w32_busy_span", 64'(busy_cyc32), 64'(4 * FRAME + 3 * 2 + 4));
    chk("w32_rd_count", 64'(rd_cnt32), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
